// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types and default geometry for the OV7670 capture path
package ov7670_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    CHECK    = 2'd3
  } state_t;

  localparam int OV_H_PIXELS = 640;
  localparam int OV_V_LINES  = 480;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - registers one camera signal and produces registered rise/fall pulses
module sync_edge_det (
  input  logic pclk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q    <= d;
      rise <= ~q & d;
      fall <= q & ~d;
    end
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - OV7670 frame capture sequencer with geometry check
// Optional double buffering of bank_sel when FRAME_PINGPONG_EN is defined.
module frame_capture_ctrl
  import ov7670_pkg::*;
#(
  parameter int H_PIXELS = OV_H_PIXELS,
  parameter int V_LINES  = OV_V_LINES,
  parameter int CNT_W    = 10,
  parameter int FCNT_W   = 8
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic              pix_wr,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  output logic              capture_en,
  output logic              bank_sel,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_t state_q, state_d;

  logic sof, eof, eol;
  logic unused_vs_q, unused_hr_q, unused_hr_rise;

  logic             cont_q, stop_pend, err_flag, frame_good;
  logic             frame_done_q, frame_err_q;
  logic [CNT_W-1:0] pix_cnt, line_cnt, pix_next;
  logic [FCNT_W-1:0] frame_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // vsync falling edge opens a frame, rising edge closes it; href fall ends a line
  sync_edge_det u_vsync (
    .pclk (pclk),
    .rst_n(rst_n),
    .d    (vsync),
    .q    (unused_vs_q),
    .rise (eof),
    .fall (sof)
  );

  sync_edge_det u_href (
    .pclk (pclk),
    .rst_n(rst_n),
    .d    (href),
    .q    (unused_hr_q),
    .rise (unused_hr_rise),
    .fall (eol)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (stop)     state_d = IDLE;
        else if (sof) state_d = ACTIVE;
      end
      ACTIVE:   if (eof) state_d = CHECK;
      CHECK:    state_d = (cont_q && !(stop_pend || stop)) ? WAIT_SOF : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    capture_en = 1'b0;
    busy       = 1'b0;
    frame_good = 1'b0;
    capture_en = (state_q == ACTIVE);
    busy       = (state_q != IDLE);
    frame_good = (state_q == CHECK) && !err_flag && (line_cnt == CNT_W'(V_LINES));
  end

  // A pixel landing in the same cycle as end-of-line belongs to that line.
  assign pix_next = pix_wr ? sat_inc(pix_cnt) : pix_cnt;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q       <= 1'b0;
      stop_pend    <= 1'b0;
      err_flag     <= 1'b0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q == IDLE && start) begin
        cont_q    <= continuous;
        stop_pend <= 1'b0;
      end
      if ((state_q == ACTIVE || state_q == CHECK) && stop) stop_pend <= 1'b1;
      if (state_q == WAIT_SOF && sof) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        err_flag <= 1'b0;
      end
      if (state_q == ACTIVE) begin
        if (eol) begin
          if (pix_next != CNT_W'(H_PIXELS)) err_flag <= 1'b1;
          line_cnt <= sat_inc(line_cnt);
          pix_cnt  <= '0;
        end else begin
          pix_cnt <= pix_next;
        end
      end
      if (state_q == CHECK) begin
        err_flag <= 1'b0;
        if (frame_good) begin
          frame_done_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + FCNT_W'(1);
        end else begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

`ifdef FRAME_PINGPONG_EN
  logic bank_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)          bank_q <= 1'b0;
    else if (frame_good) bank_q <= ~bank_q;
  end

  assign bank_sel = bank_q;
`else
  assign bank_sel = 1'b0;
`endif

  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - directed self-checking bench for frame_capture_ctrl (H=4, V=2)
module tb_frame_capture_ctrl;

`ifdef FRAME_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic       pclk = 1'b0;
  logic       rst_n, vsync, href, pix_wr, start, continuous, stop;
  logic       capture_en, bank_sel, busy, frame_done, frame_err;
  logic [7:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  bit exp_par = 1'b0;

  frame_capture_ctrl #(
    .H_PIXELS(4),
    .V_LINES (2),
    .CNT_W   (10),
    .FCNT_W  (8)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .href      (href),
    .pix_wr    (pix_wr),
    .start     (start),
    .continuous(continuous),
    .stop      (stop),
    .capture_en(capture_en),
    .bank_sel  (bank_sel),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input bit cont);
    continuous = cont;
    start      = 1'b1;
    step();
    start      = 1'b0;
    continuous = 1'b0;
    chk("arm_busy", busy, 1);
  endtask

  // n pixels per line; with coinc the last pixel lands in the end-of-line cycle
  task automatic line(input int n, input bit coinc);
    int k;
    k = coinc ? n - 1 : n;
    href = 1'b1;
    for (int i = 0; i < k; i++) begin
      pix_wr = 1'b1;
      step();
    end
    pix_wr = 1'b0;
    href   = 1'b0;
    step();
    pix_wr = coinc;
    step();
    pix_wr = 1'b0;
    step();
  endtask

  task automatic frame(input int n0, input int n1, input bit coinc, input bit stop_mid,
                       input bit good, input bit end_idle);
    vsync = 1'b0;
    step();
    chk("cap_sof1", capture_en, 0);
    step();
    chk("cap_sof2", capture_en, 1);
    line(n0, coinc);
    if (stop_mid) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
    end
    line(n1, coinc);
    vsync = 1'b1;
    step();
    chk("cap_eof1", capture_en, 1);
    step();
    chk("cap_eof2", capture_en, 0);
    chk("done_eof2", frame_done, 0);
    step();
    if (good) begin
      exp_cnt++;
      exp_par = ~exp_par;
    end
    chk("frame_done", frame_done, good);
    chk("frame_err", frame_err, !good);
    chk("frame_cnt", frame_cnt, exp_cnt);
    chk("bank_sel", bank_sel, PP & exp_par);
    chk("busy_end", busy, !end_idle);
    step();
    chk("done_pulse", frame_done, 0);
    chk("err_pulse", frame_err, 0);
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b1; href = 1'b0; pix_wr = 1'b0;
    start = 1'b0; continuous = 1'b0; stop = 1'b0;
    step();
    chk("rst_cap", capture_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_bank", bank_sel, 0);
    rst_n = 1'b1;
    step();
    step();

    // short second line
    arm(1'b0);
    frame(4, 3, 1'b0, 1'b0, 1'b0, 1'b1);

    // single shot good frame
    arm(1'b0);
    frame(4, 4, 1'b0, 1'b0, 1'b1, 1'b1);

    // last pixel coincident with end of line
    arm(1'b0);
    frame(4, 4, 1'b1, 1'b0, 1'b1, 1'b1);

    // continuous: three frames, stop during the third
    arm(1'b1);
    frame(4, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(4, 4, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(4, 4, 1'b0, 1'b1, 1'b1, 1'b1);
    vsync = 1'b0;
    step();
    step();
    chk("f4_cap", capture_en, 0);
    line(4, 1'b0);
    vsync = 1'b1;
    step();
    step();
    step();
    chk("f4_done", frame_done, 0);
    chk("f4_busy", busy, 0);
    chk("f4_cnt", frame_cnt, exp_cnt);
    step();

    // armed mid-frame: first eof ignored
    vsync = 1'b0;
    step();
    step();
    arm(1'b0);
    line(4, 1'b0);
    vsync = 1'b1;
    step();
    step();
    step();
    chk("mid_cap", capture_en, 0);
    chk("mid_done", frame_done, 0);
    chk("mid_err", frame_err, 0);
    chk("mid_busy", busy, 1);
    frame(4, 4, 1'b0, 1'b0, 1'b1, 1'b1);

    // reset while capturing
    arm(1'b0);
    vsync = 1'b0;
    step();
    step();
    chk("ar_cap", capture_en, 1);
    href   = 1'b1;
    pix_wr = 1'b1;
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_rst_cap", capture_en, 0);
    chk("ar_rst_busy", busy, 0);
    chk("ar_rst_cnt", frame_cnt, 0);
    chk("ar_rst_bank", bank_sel, 0);
    chk("ar_rst_done", frame_done, 0);
    chk("ar_rst_err", frame_err, 0);
    href   = 1'b0;
    pix_wr = 1'b0;
    vsync  = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    exp_cnt = 0;
    exp_par = 1'b0;
    arm(1'b0);
    frame(4, 4, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
